// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared constants and channel FSM states for the I2C mux/receiver pair
package i2c_pkg;

    localparam int I2C_NUM_CHANNELS = 8;
    localparam int I2C_SEL_WIDTH    = $clog2(I2C_NUM_CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        SWITCH,
        SETTLE
    } chan_state_e;

endpackage

// File: rtl/i2c_channel_receiver_if.sv
// rtl/i2c_channel_receiver_if.sv - bus lines, channel select handshake and filtered outputs
interface i2c_channel_receiver_if
    import i2c_pkg::*;
#(
    parameter int NUM_CHANNELS = I2C_NUM_CHANNELS,
    parameter int SEL_WIDTH    = I2C_SEL_WIDTH
);
    logic [NUM_CHANNELS-1:0] sclIn;
    logic [NUM_CHANNELS-1:0] sdaIn;
    logic [SEL_WIDTH-1:0]    selReq;
    logic                    selValid;
    logic [SEL_WIDTH-1:0]    activeSel;
    logic                    selAck;
    logic                    sclOut;
    logic                    dataOut;
    logic                    startDet;
    logic                    stopDet;
    logic                    busBusy;

    modport slave (
        input  sclIn, sdaIn, selReq, selValid,
        output activeSel, selAck, sclOut, dataOut, startDet, stopDet, busBusy
    );

    modport master (
        output sclIn, sdaIn, selReq, selValid,
        input  activeSel, selAck, sclOut, dataOut, startDet, stopDet, busBusy
    );
endinterface

// File: rtl/glitch_filter.sv
// rtl/glitch_filter.sv - single-line deglitcher: output follows input after FILTER_CYCLES stable cycles
module glitch_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic loadVal,
    input  logic in,
    output logic out
);
    localparam int             CW    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(FILTER_CYCLES);
    localparam logic [CW-1:0]  ONE   = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = '0;
        out_d = out_q;
        if (load) begin
            out_d = loadVal;
        end else if (in != out_q) begin
            if (cnt_q + ONE == LIMIT) begin
                out_d = in;
            end else begin
                cnt_d = cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            out_q <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: rtl/i2c_channel_receiver.sv
// rtl/i2c_channel_receiver.sv - selects one of several I2C buses, deglitches it, detects START/STOP
module i2c_channel_receiver
    import i2c_pkg::*;
#(
    parameter int NUM_CHANNELS  = I2C_NUM_CHANNELS,
    parameter int SEL_WIDTH     = I2C_SEL_WIDTH,
    parameter int FILTER_CYCLES = 4
) (
    input logic                   clk,
    input logic                   reset,
    i2c_channel_receiver_if.slave bus
);
    localparam int                SCW         = $clog2(FILTER_CYCLES + 1);
    localparam logic [SCW-1:0]    SETTLE_LAST = SCW'(FILTER_CYCLES - 1);
    localparam logic [SCW-1:0]    SCW_ONE     = SCW'(1);

    logic [NUM_CHANNELS-1:0] scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;

    chan_state_e          state_q, state_d;
    logic [SEL_WIDTH-1:0] req_q, req_d;
    logic                 pend_q, pend_d;
    logic [SEL_WIDTH-1:0] active_q, active_d;
    logic [SCW-1:0]       settle_q, settle_d;
    logic                 ack_q, ack_d;
    logic                 start_q, start_d;
    logic                 stop_q, stop_d;
    logic                 busy_q, busy_d;
    logic                 scl_prev_q, scl_prev_d;
    logic                 sda_prev_q, sda_prev_d;

    logic                 in_switch;
    logic                 new_scl, new_sda;
    logic                 scl_f, sda_f;
    logic                 want;
    logic [SEL_WIDTH-1:0] want_req;

    assign in_switch = (state_q == SWITCH);
    assign new_scl   = scl_s2_q[req_q];
    assign new_sda   = sda_s2_q[req_q];

    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_scl_filter (
        .clk     (clk),
        .reset   (reset),
        .load    (in_switch),
        .loadVal (new_scl),
        .in      (scl_s2_q[active_q]),
        .out     (scl_f)
    );

    glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_sda_filter (
        .clk     (clk),
        .reset   (reset),
        .load    (in_switch),
        .loadVal (new_sda),
        .in      (sda_s2_q[active_q]),
        .out     (sda_f)
    );

    // Previous-level registers are preloaded with the new channel so the switch itself looks edge-free
    always_comb begin
        scl_prev_d = in_switch ? new_scl : scl_f;
        sda_prev_d = in_switch ? new_sda : sda_f;
        start_d    = ~in_switch & scl_prev_q & scl_f & sda_prev_q & ~sda_f;
        stop_d     = ~in_switch & scl_prev_q & scl_f & ~sda_prev_q & sda_f;
        busy_d     = busy_q;
        if (in_switch) begin
            busy_d = ~(new_scl & new_sda);
        end else if (start_d) begin
            busy_d = 1'b1;
        end else if (stop_d) begin
            busy_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        pend_d   = pend_q;
        active_d = active_q;
        settle_d = settle_q;
        ack_d    = 1'b0;
        want     = bus.selValid | pend_q;
        want_req = bus.selValid ? bus.selReq : req_q;
        case (state_q)
            IDLE: begin
                if (want) begin
                    pend_d = 1'b0;
                    req_d  = want_req;
                    if (want_req == active_q) begin
                        ack_d = 1'b1;
                    end else if (busy_q) begin
                        state_d = PENDING;
                    end else begin
                        state_d = SWITCH;
                    end
                end
            end
            PENDING: begin
                if (bus.selValid) begin
                    req_d = bus.selReq;
                end
                if (stop_q) begin
                    state_d = SWITCH;
                end
            end
            SWITCH: begin
                active_d = req_q;
                settle_d = '0;
                state_d  = SETTLE;
                if (bus.selValid) begin
                    req_d  = bus.selReq;
                    pend_d = 1'b1;
                end
            end
            SETTLE: begin
                if (bus.selValid) begin
                    req_d  = bus.selReq;
                    pend_d = 1'b1;
                end
                if (settle_q == SETTLE_LAST) begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    settle_d = settle_q + SCW_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1_q   <= '1;
            scl_s2_q   <= '1;
            sda_s1_q   <= '1;
            sda_s2_q   <= '1;
            state_q    <= IDLE;
            req_q      <= '0;
            pend_q     <= 1'b0;
            active_q   <= '0;
            settle_q   <= '0;
            ack_q      <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= bus.sclIn;
            scl_s2_q   <= scl_s1_q;
            sda_s1_q   <= bus.sdaIn;
            sda_s2_q   <= sda_s1_q;
            state_q    <= state_d;
            req_q      <= req_d;
            pend_q     <= pend_d;
            active_q   <= active_d;
            settle_q   <= settle_d;
            ack_q      <= ack_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign bus.activeSel = active_q;
    assign bus.selAck    = ack_q;
    assign bus.sclOut    = scl_f;
    assign bus.dataOut   = sda_f;
    assign bus.startDet  = start_q;
    assign bus.stopDet   = stop_q;
    assign bus.busBusy   = busy_q;
endmodule

// File: doc/i2c_channel_receiver.md
# i2c_channel_receiver

Receive side for the eight open-drain I2C channels driven by the team's open-drain demultiplexer. It samples SCL/SDA from all channels, synchronizes and deglitches the selected channel, and presents clean SCL/SDA levels plus START/STOP pulses and a bus-busy flag to the I2C controller. Channel changes requested while a transaction is in progress are deferred until STOP, so a bus is never abandoned mid-transfer.

## Interface
- NUM_CHANNELS, 8, number of open-drain buses
- SEL_WIDTH, 3, width of channel index ($clog2(NUM_CHANNELS))
- FILTER_CYCLES, 4, consecutive stable cycles needed before a filtered line changes (≥1)

- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- sclIn  input  NUM_CHANNELS  raw SCL of each bus (pulled-up, asynchronous)
- sdaIn  input  NUM_CHANNELS  raw SDA of each bus (pulled-up, asynchronous)
- selReq  input  SEL_WIDTH  requested channel
- selValid  input  1  one-cycle request strobe for selReq
- activeSel  output  SEL_WIDTH  channel currently monitored
- selAck  output  1  one-cycle pulse: requested channel is active and settled
- sclOut  output  1  filtered SCL of active channel
- dataOut  output  1  filtered SDA of active channel
- startDet  output  1  one-cycle START pulse
- stopDet  output  1  one-cycle STOP pulse
- busBusy  output  1  high between START and STOP on the active channel

## Operation
- Reset values: activeSel=0, selAck=0, sclOut=1, dataOut=1, startDet=0, stopDet=0, busBusy=0. All synchronizer flops reset to 1. FSM enters IDLE. Filter counters reset to 0.
- Two-flop synchronizer on every bit of sclIn and sdaIn, regardless of selection.
- Glitch filter on each line (SCL, SDA) of the active channel: a counter counts cycles in which the synced value differs from the filtered output. It resets to 0 whenever the two agree. When the count reaches FILTER_CYCLES, the filtered output takes the synced value and the counter clears.
- START: dataOut goes 1→0 while sclOut is 1 both before and after the update. STOP: dataOut goes 0→1 under the same SCL condition. If SCL and SDA both change in the same cycle, neither START nor STOP is detected.
- busBusy is set on START and cleared on STOP. A repeated START leaves it set.
- Channel FSM:
  - IDLE
    - On selValid with busBusy=0: go to SWITCH.
    - On selValid with busBusy=1: latch selReq and go to PENDING.
  - PENDING
    - On stopDet: go to SWITCH.
    - A new selValid overwrites the latched request.
  - SWITCH (1 cycle)
    - activeSel takes the latched request.
    - Filtered outputs are preloaded from the new channel's synced values and filter counters clear.
    - START/STOP detection is suppressed.
    - busBusy is set to ~(sclSync & sdaSync) of the new channel.
    - Go to SETTLE.
  - SETTLE
    - Hold for FILTER_CYCLES cycles, then pulse selAck and return to IDLE.
    - selValid arriving in SETTLE is latched and serviced on return to IDLE (to SWITCH or PENDING, by busBusy at that point).
  - selValid for the already-active channel in IDLE: no switch. selAck pulses on the next cycle.
- Reset asserted in any state aborts pending/settling requests and returns to the reset values; no selAck is issued.

## Timing
- Raw input edge to sclOut/dataOut change: 2 (sync) + FILTER_CYCLES cycles, for a stable input.
- Pulses narrower than FILTER_CYCLES cycles (after sync) never reach the outputs.
- startDet/stopDet assert in the cycle after the filtered update and last exactly one cycle. busBusy changes in the same cycle as the pulse.
- Idle-bus switch: selValid at cycle 0 → SWITCH at cycle 1 (activeSel updated at end of cycle 1) → selAck in cycle 2+FILTER_CYCLES.
- Busy-bus switch: SWITCH occurs in the cycle after stopDet.
- selAck and startDet/stopDet are never asserted in SETTLE for transitions caused by the switch itself.

## Structure
- Shared package i2c_pkg holds the FSM state enum (IDLE, PENDING, SWITCH, SETTLE) and the default NUM_CHANNELS/SEL_WIDTH constants used by the demultiplexer and this block.
- Sub-module glitch_filter: one line, parameter FILTER_CYCLES, with ports clk, reset, load, loadVal, in, out. The block instantiates it twice (SCL, SDA).
- Synchronizers are inline flop arrays, not a separate module.

## Test plan
- Reset, all lines high → all outputs at their reset values; after reset release, sclOut=dataOut=1 and busBusy=0 for 20 cycles.
- Channel 0, SCL held high, SDA falls and is held 10 cycles → dataOut=0 at cycle 6, startDet pulse at cycle 7, busBusy=1. SDA rises → stopDet pulse, busBusy=0.
- SDA glitch low for 3 synced cycles (FILTER_CYCLES=4) → dataOut stays 1, no startDet.
- Idle bus, selValid with selReq=5 → activeSel=5 after cycle 1, selAck in cycle 6. Toggles on channel 5 SDA appear on dataOut; toggles on channel 0 do not.
- Busy channel 0 (after START), selValid selReq=2, then selReq=3 while PENDING → no switch until STOP. Then activeSel=3 and a single selAck.
- Switch to channel 4 while its SCL is held low → busBusy=1 after SWITCH, no startDet/stopDet generated by the switch.
